// File: rtl/fwd_pkg.sv
//------------------------------------------------------------------------------
// fwd_pkg : shared types and constants for the EX-stage forwarding tracker.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package fwd_pkg;

  localparam int DEF_XLEN    = 16;
  localparam int DEF_NREGS   = 8;
  localparam int DEF_NRD     = 2;
  localparam int DEF_DEPTH   = 2;
  localparam int DEF_R0_ZERO = 0;

  // Tracked destination field is sized for up to 32 architectural registers
  localparam int RD_W            = 5;
  localparam int STAT_W          = 16;
  localparam int RETURN_ADDR_REG = 7;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } fwd_entry_t;

  function automatic logic entry_writes(input fwd_entry_t e);
    return e.valid & e.we;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_track_unit_if.sv
//------------------------------------------------------------------------------
// fwd_track_unit_if : issue/tracking/operand bus between the EX pipeline and
//                     the forwarding tracker.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fwd_track_unit_if
  import fwd_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = $clog2(NREGS);

  logic                  issue_valid;
  logic                  issue_we;
  logic [AW-1:0]         issue_rd;
  logic                  issue_is_load;
  logic                  advance;
  logic                  flush;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic [NRD*AW-1:0]     rs_addr;
  logic [NRD*XLEN-1:0]   rf_data;
  logic [NRD*XLEN-1:0]   fwd_data;
  logic [NRD-1:0]        fwd_hit;
  logic                  load_use_stall;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_is_load, advance, flush,
           stage_data, rs_addr, rf_data,
    input  fwd_data, fwd_hit, load_use_stall
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_is_load, advance, flush,
           stage_data, rs_addr, rf_data,
    output fwd_data, fwd_hit, load_use_stall
  );

endinterface

`default_nettype wire

// File: rtl/fwd_track_unit_port_sel.sv
//------------------------------------------------------------------------------
// fwd_port_sel : youngest-match operand selection and load-use detection for
//                one read port.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int AW      = 3,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int R0_ZERO = DEF_R0_ZERO
) (
  input  fwd_entry_t [DEPTH-1:0]      entries,
  input  logic       [DEPTH*XLEN-1:0] stage_data,
  input  logic       [AW-1:0]         rs,
  input  logic       [XLEN-1:0]       rf,
  output logic       [XLEN-1:0]       data,
  output logic                        hit,
  output logic                        stall
);

  logic [DEPTH-1:0] w_match;
  logic [DEPTH-1:0] w_ready;
  logic             w_rs_ok;
  logic [XLEN-1:0]  w_older_data;
  logic             w_older_hit;

  assign w_rs_ok = (R0_ZERO == 0) || (rs != '0);

  // A load's result only exists from entry 1 onward
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign w_match[i] = entry_writes(entries[i]) &&
                        (entries[i].rd == RD_W'(rs)) && w_rs_ok;
    assign w_ready[i] = (i != 0) || !entries[i].is_load;
  end

  always_comb begin
    w_older_hit  = 1'b0;
    w_older_data = rf;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (w_match[i] && w_ready[i]) begin
        w_older_hit  = 1'b1;
        w_older_data = stage_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    stall = w_match[0] & ~w_ready[0];
    if (w_match[0] && w_ready[0]) begin
      data = stage_data[XLEN-1:0];
      hit  = 1'b1;
    end else begin
      data = w_older_data;
      hit  = w_older_hit;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_track_unit.sv
//------------------------------------------------------------------------------
// fwd_track_unit : in-flight writer tracking, operand forwarding and load-use
//                  stall for the EX stage. Optional counters: FWD_STATS_EN.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwd_track_unit
  import fwd_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREGS   = DEF_NREGS,
  parameter int NRD     = DEF_NRD,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int R0_ZERO = DEF_R0_ZERO
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_track_unit_if.slave   bus,
  output logic [STAT_W-1:0] stat_fwd,
  output logic [STAT_W-1:0] stat_stall
);

  localparam int AW = $clog2(NREGS);

  fwd_entry_t [DEPTH-1:0] r_entry;
  fwd_entry_t             w_new;
  logic [NRD*XLEN-1:0]    w_fwd_data;
  logic [NRD-1:0]         w_fwd_hit;
  logic [NRD-1:0]         w_port_stall;
  logic                   w_stall;

  // A stalled or flushed EX instruction is recorded as a bubble
  assign w_new = '{valid:   bus.issue_valid & ~bus.flush & ~w_stall,
                   we:      bus.issue_we,
                   rd:      RD_W'(bus.issue_rd),
                   is_load: bus.issue_is_load};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_entry <= '0;
    end else if (bus.advance || bus.flush) begin
      r_entry[0] <= w_new;
      for (int i = 1; i < DEPTH; i++) begin
        r_entry[i] <= r_entry[i-1];
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port_sel #(
      .XLEN    (XLEN),
      .AW      (AW),
      .DEPTH   (DEPTH),
      .R0_ZERO (R0_ZERO)
    ) u_sel (
      .entries    (r_entry),
      .stage_data (bus.stage_data),
      .rs         (bus.rs_addr[p*AW +: AW]),
      .rf         (bus.rf_data[p*XLEN +: XLEN]),
      .data       (w_fwd_data[p*XLEN +: XLEN]),
      .hit        (w_fwd_hit[p]),
      .stall      (w_port_stall[p])
    );
  end

  assign w_stall            = |w_port_stall;
  assign bus.fwd_data       = w_fwd_data;
  assign bus.fwd_hit        = w_fwd_hit;
  assign bus.load_use_stall = w_stall;

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] r_stat_fwd;
  logic [STAT_W-1:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_fwd   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (bus.advance && (|w_fwd_hit) && (r_stat_fwd != '1))
        r_stat_fwd <= r_stat_fwd + 1'b1;
      if (w_stall && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_fwd   = r_stat_fwd;
  assign stat_stall = r_stat_stall;
`else
  assign stat_fwd   = '0;
  assign stat_stall = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_track_unit.sv
//------------------------------------------------------------------------------
// tb_fwd_track_unit : directed scoreboard bench for fwd_track_unit, with a
//                     second instance built with R0_ZERO=1.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fwd_track_unit;
  import fwd_pkg::*;

  localparam int XLEN  = 16;
  localparam int NREGS = 8;
  localparam int NRD   = 2;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_track_unit_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .DEPTH(DEPTH)) bus0 ();
  fwd_track_unit_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .DEPTH(DEPTH)) bus1 ();

  logic [15:0] stat_fwd, stat_stall, stat_fwd1, stat_stall1;

  fwd_track_unit #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .DEPTH(DEPTH), .R0_ZERO(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .stat_fwd(stat_fwd), .stat_stall(stat_stall)
  );

  fwd_track_unit #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .DEPTH(DEPTH), .R0_ZERO(1)) dut_r0 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .stat_fwd(stat_fwd1), .stat_stall(stat_stall1)
  );

  assign bus1.issue_valid   = bus0.issue_valid;
  assign bus1.issue_we      = bus0.issue_we;
  assign bus1.issue_rd      = bus0.issue_rd;
  assign bus1.issue_is_load = bus0.issue_is_load;
  assign bus1.advance       = bus0.advance;
  assign bus1.flush         = bus0.flush;
  assign bus1.stage_data    = bus0.stage_data;
  assign bus1.rs_addr       = bus0.rs_addr;
  assign bus1.rf_data       = bus0.rf_data;

  typedef struct {
    int          step;
    logic [31:0] data;
    logic [1:0]  hit;
    logic        stall;
    bit          chk1;
    logic [31:0] data1;
    logic [1:0]  hit1;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [31:0] RF = {16'h2222, 16'h1111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] rd,
                       input logic ld, input logic adv, input logic fl);
    bus0.issue_valid   = v;
    bus0.issue_we      = we;
    bus0.issue_rd      = rd;
    bus0.issue_is_load = ld;
    bus0.advance       = adv;
    bus0.flush         = fl;
  endtask

  task automatic ports(input logic [2:0] a0, input logic [2:0] a1);
    bus0.rs_addr = {a1, a0};
  endtask

  task automatic expect_out(input int step, input logic [31:0] data,
                            input logic [1:0] hit, input logic stall);
    exp_t e;
    e.step = step; e.data = data; e.hit = hit; e.stall = stall;
    e.chk1 = 1'b0; e.data1 = '0; e.hit1 = '0;
    sb.push_back(e);
  endtask

  task automatic expect_both(input int step, input logic [31:0] data, input logic [1:0] hit,
                             input logic [31:0] data1, input logic [1:0] hit1);
    exp_t e;
    e.step = step; e.data = data; e.hit = hit; e.stall = 1'b0;
    e.chk1 = 1'b1; e.data1 = data1; e.hit1 = hit1;
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("s%0d_data", e.step), bus0.fwd_data, e.data);
      check($sformatf("s%0d_hit", e.step), 32'(bus0.fwd_hit), 32'(e.hit));
      check($sformatf("s%0d_stall", e.step), 32'(bus0.load_use_stall), 32'(e.stall));
      if (e.chk1) begin
        check($sformatf("s%0d_r0_data", e.step), bus1.fwd_data, e.data1);
        check($sformatf("s%0d_r0_hit", e.step), 32'(bus1.fwd_hit), 32'(e.hit1));
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 1, 0);
    ports(2, 3);
    bus0.rf_data    = RF;
    bus0.stage_data = '0;
    rst_n = 1'b0;
    next(); next();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // reset state: operands pass through from the register file
    expect_out(1, RF, 2'b00, 1'b0);
    check("rst_stat_fwd", 32'(stat_fwd), 32'd0);
    check("rst_stat_stall", 32'(stat_stall), 32'd0);
    next();

    drive(1, 1, 2, 0, 1, 0);
    expect_out(2, RF, 2'b00, 1'b0);
    next();

    drive(0, 0, 0, 0, 0, 0);
    bus0.stage_data = {16'h5555, 16'hABCD};
    expect_out(3, {16'h2222, 16'hABCD}, 2'b01, 1'b0);
    next();

    drive(1, 1, 3, 0, 1, 0);
    expect_out(4, {16'h2222, 16'hABCD}, 2'b01, 1'b0);
    next();

    // r3 in both entries after this edge; r2 now in entry 1
    drive(1, 1, 3, 0, 1, 0);
    bus0.stage_data = {16'h7777, 16'h0001};
    expect_out(5, {16'h0001, 16'h7777}, 2'b11, 1'b0);
    next();

    drive(0, 0, 0, 0, 0, 0);
    bus0.stage_data = {16'h0001, 16'h0002};
    ports(3, 2);
    expect_out(6, {16'h2222, 16'h0002}, 2'b01, 1'b0);
    next();

    drive(1, 1, 4, 1, 1, 0);
    expect_out(7, {16'h2222, 16'h0002}, 2'b01, 1'b0);
    next();

    // load r4 in entry 0: port0 stalls, port1 still forwards r3 from entry 1
    drive(0, 0, 0, 0, 0, 0);
    ports(4, 3);
    bus0.stage_data = {16'h3333, 16'hDEAD};
    expect_out(8, {16'h3333, 16'h1111}, 2'b10, 1'b1);
    next();

    drive(1, 1, 6, 0, 1, 0);
    expect_out(9, {16'h3333, 16'h1111}, 2'b10, 1'b1);
    next();

    // stalled r6 became a bubble; the load now forwards from entry 1
    drive(0, 0, 0, 0, 0, 0);
    ports(4, 6);
    bus0.stage_data = {16'h4444, 16'h6666};
    expect_out(10, {16'h2222, 16'h4444}, 2'b01, 1'b0);
`ifdef FWD_STATS_EN
    check("stat_fwd_cnt", 32'(stat_fwd), 32'd4);
    check("stat_stall_cnt", 32'(stat_stall), 32'd2);
`else
    check("stat_fwd_off", 32'(stat_fwd), 32'd0);
    check("stat_stall_off", 32'(stat_stall), 32'd0);
`endif
    next();

    // flush without advance still shifts, and the flushed issue is a bubble
    drive(1, 1, 5, 0, 0, 1);
    ports(5, 4);
    expect_out(11, {16'h4444, 16'h1111}, 2'b10, 1'b0);
    next();

    drive(0, 0, 0, 0, 0, 0);
    ports(5, 6);
    expect_out(12, RF, 2'b00, 1'b0);
    next();

    drive(1, 1, 0, 0, 1, 0);
    expect_out(13, RF, 2'b00, 1'b0);
    next();

    drive(0, 0, 0, 0, 0, 0);
    ports(0, 0);
    bus0.stage_data = {16'h0000, 16'h0F0F};
    expect_both(14, {16'h0F0F, 16'h0F0F}, 2'b11, RF, 2'b00);
    next();

    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    expect_out(15, RF, 2'b00, 1'b0);
    check("rst2_stat_fwd", 32'(stat_fwd), 32'd0);
    check("rst2_stat_stall", 32'(stat_stall), 32'd0);
    next();

`ifdef FWD_STATS_EN
    drive(1, 1, 4, 1, 1, 0);
    ports(1, 1);
    expect_out(16, RF, 2'b00, 1'b0);
    next();
    drive(0, 0, 0, 0, 0, 0);
    ports(4, 1);
    expect_out(17, RF, 2'b00, 1'b1);
    repeat (65540) next();
    check("stat_stall_sat", 32'(stat_stall), 32'h0000_FFFF);
    check("sat_stall_still", 32'(bus0.load_use_stall), 32'd1);
    next();
    check("stat_stall_sat2", 32'(stat_stall), 32'h0000_FFFF);
`endif

    next();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
